// File: rtl/updown_counter_ext.sv
// Parametrised up/down counter with programmable limit, variable step,
// wrap/saturate modes, clear/load, terminal flags, event pulse and sticky error.
module updown_counter_ext #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  input  logic         sat_mode,
  output logic [W-1:0] cnt,
  output logic         at_max,
  output logic         at_min,
  output logic         evt,
  output logic         err
);

  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  logic [W-1:0] cnt_d;
  logic         evt_d;
  logic         err_d;

  logic [W:0]   lim_x;
  logic [W:0]   lim1;
  logic [W:0]   sum;
  logic         up_ovf;
  logic         dn_ovf;
  logic         over_lim;
  logic         bad_step;
  logic [W-1:0] ld_val;

  // limit+1 needs W+1 bits so limit == 2**W-1 wraps naturally
  assign lim_x    = {1'b0, limit};
  assign lim1     = lim_x + ONE;
  assign sum      = {1'b0, cnt} + {1'b0, step};
  assign up_ovf   = sum > lim_x;
  assign dn_ovf   = step > cnt;
  assign over_lim = cnt > limit;
  assign bad_step = step > limit;
  assign ld_val   = (load_val > limit) ? limit : load_val;

  always_comb begin
    cnt_d = cnt;
    evt_d = 1'b0;
    err_d = err;
    priority case (1'b1)
      clear: begin
        cnt_d = RST_VAL;
        err_d = 1'b0;
      end
      load: cnt_d = ld_val;
      !en: ;
      over_lim: begin
        cnt_d = limit;
        evt_d = 1'b1;
      end
      bad_step: err_d = 1'b1;
      step == '0: ;
      up: begin
        if (up_ovf) begin
          evt_d = 1'b1;
          cnt_d = sat_mode ? limit : W'(sum - lim1);
        end else begin
          cnt_d = W'(sum);
        end
      end
      default: begin
        if (dn_ovf) begin
          evt_d = 1'b1;
          cnt_d = sat_mode ? '0
                : W'({1'b0, cnt} + lim1 - {1'b0, step});
        end else begin
          cnt_d = cnt - step;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
      evt <= 1'b0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_d;
      evt <= evt_d;
      err <= err_d;
    end
  end

  assign at_max = (cnt == limit);
  assign at_min = (cnt == '0);

endmodule

// File: doc/updown_counter_ext.md
Name: updown_counter_ext

Overview:
- Parametrised up/down counter; next generation of the team's basic 8-bit up/down counter.
- Adds:
  - programmable terminal value (limit)
  - variable step
  - wrap or saturate mode
  - synchronous clear and load
  - terminal flags, a registered wrap/saturate event pulse, and a sticky illegal-step error
- Sits in timer/event-count datapaths; status outputs feed control FSMs directly.

Parameters:
- W, 8, counter/limit/step width in bits (W >= 2).
- RST_VAL, 0, value loaded into cnt on reset and on clear. Must be <= 2**W-1.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous clear to RST_VAL; highest synchronous priority.
- load, input, 1, synchronous load of load_val.
- load_val, input, W, value for load.
- en, input, 1, count enable.
- up, input, 1, 1 = count up, 0 = count down.
- step, input, W, increment/decrement amount per enabled cycle.
- limit, input, W, terminal value; legal count range is 0..limit.
- sat_mode, input, 1, 1 = saturate at 0/limit, 0 = wrap modulo (limit+1).
- cnt, output, W, current count (register).
- at_max, output, 1, cnt == limit (combinational from cnt, limit).
- at_min, output, 1, cnt == 0 (combinational from cnt).
- evt, output, 1, registered one-cycle pulse: previous enabled step wrapped or saturated.
- err, output, 1, sticky: an enabled step with step > limit occurred.

Behaviour:
- Reset (rst_n low, asynchronous): cnt = RST_VAL, evt = 0, err = 0. Release is synchronous to clk by the surrounding reset logic.
- Priority per edge: clear > load > en > hold.
- clear: cnt <= RST_VAL, evt <= 0, err <= 0.
- load: cnt <= min(load_val, limit), evt <= 0, err unchanged.
- en=0 (no clear/load): cnt holds, evt <= 0.
- en=1 with cnt > limit (limit lowered at runtime): cnt <= limit, evt <= 1; step and up are ignored that cycle.
- en=1 with step > limit: cnt holds, err <= 1, evt <= 0.
- en=1 with step == 0: cnt holds, evt <= 0.
- en=1 otherwise (0 < step <= limit, cnt <= limit). Compute in W+1 bits, no intermediate truncation:
  - up, cnt+step <= limit: cnt <= cnt+step, evt <= 0.
  - up, cnt+step > limit:
    - sat_mode=1: cnt <= limit, evt <= 1.
    - sat_mode=0: cnt <= cnt+step-(limit+1), evt <= 1.
  - down, step <= cnt: cnt <= cnt-step, evt <= 0.
  - down, step > cnt:
    - sat_mode=1: cnt <= 0, evt <= 1.
    - sat_mode=0: cnt <= cnt+(limit+1)-step, evt <= 1.
- Saturation pulse rule: evt asserts when the limit is hit by clamping, even if cnt was already at limit/0. Example: sat_mode=1, up, cnt==limit, en=1 → evt pulses every enabled cycle.
- limit == 2**W-1: limit+1 needs W+1 bits; wrap then equals natural modulo 2**W (matches the legacy counter with step=1).
- limit == 0: any step >= 1 is illegal → err sets and cnt stays 0.
- Latency: cnt and evt update one cycle after the qualifying inputs. at_max and at_min follow cnt with zero extra latency.
- up, step, limit and sat_mode are sampled only on enabled cycles; no internal registering of them.

Test Plan:
- W=8, RST_VAL=0, limit=255, step=1, sat_mode=0, en=1, up=1 for 260 cycles → cnt = 0,1,…,255,0,1,2,3; evt pulses exactly once, the cycle after cnt 255→0.
- limit=9, step=3, up=1, sat_mode=0 from cnt=0 → cnt 3,6,9,2,5; evt high only for the cycle after 9→2. Switch to up=0 at cnt=5 → 2,9,6; evt after 2→9.
- limit=9, step=4, sat_mode=1, up=1 from cnt=0 → cnt 4,8,9,9; evt after 8→9 and again after 9→9. at_max=1 once cnt=9. Then up=0 → 5,1,0; at_min=1.
- limit=9, step=12, en=1 → cnt holds, err=1 and stays 1 after step=1 resumes counting. clear=1 → cnt=0, err=0.
- Priority: clear=1, load=1, load_val=7, en=1 in the same cycle → cnt=0. Same cycle without clear → cnt=7. load_val=200 with limit=9 → cnt=9.
- At cnt=150 with limit=255, drop limit to 100 with en=1 → cnt=100, evt pulses. Assert rst_n=0 mid-count between clock edges → cnt=0, evt=0, err=0 immediately, before the next edge.
